// File: rtl/spi_flash_slave.sv
// SPI mode-0 NOR-flash slave model with READ (0x03) and a backdoor-loaded word array.
// Define SPI_FLASH_FAST_READ_EN to also accept FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_slave #(
  parameter int          MEM_AW   = 12,
  parameter logic [7:0]  CMD_READ = 8'h03
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              load_en,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              busy,
  output logic              cmd_err
);

  localparam int MEM_WORDS = 2 ** MEM_AW;
  localparam int PW        = MEM_AW + 2;
  localparam int SHW       = MEM_AW + 1;

`ifdef SPI_FLASH_FAST_READ_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
`endif

  state_t           r_state;
  state_t           w_nextState;
  logic             r_sckQ;
  logic             r_ssQ;
  logic [4:0]       r_bitCnt;
  logic [SHW-1:0]   r_shift;
  logic [PW-1:0]    r_ptr;
  logic [7:0]       r_txByte;
  logic             r_miso;
  logic             r_cmdErr;
  logic [31:0]      r_mem [MEM_WORDS];

  logic             w_rise;
  logic             w_fall;
  logic             w_ssFall;
  logic [7:0]       w_opcode;
  logic             w_opOk;
  logic [PW-1:0]    w_addrPtr;
  logic [PW-1:0]    w_ptrInc;
  logic [PW-1:0]    w_fetchPtr;
  logic [31:0]      w_fetchWord;
  logic [7:0]       w_fetchByte;
  logic             w_cmdErrSet;
  logic             w_enterData;

  assign w_rise    = spi_sck & ~r_sckQ;
  assign w_fall    = ~spi_sck & r_sckQ;
  assign w_ssFall  = r_ssQ & ~spi_ss_n;
  assign w_opcode  = {r_shift[6:0], spi_mosi};
  assign w_addrPtr = {r_shift, spi_mosi};
  assign w_ptrInc  = r_ptr + PW'(1);

`ifdef SPI_FLASH_FAST_READ_EN
  assign w_opOk = (w_opcode == CMD_READ) || (w_opcode == 8'h0B);
`else
  assign w_opOk = (w_opcode == CMD_READ);
`endif

  // The byte is captured at fetch time so later backdoor writes only affect subsequent bytes.
  assign w_fetchPtr  = (r_state == DATA) ? w_ptrInc :
                       (r_state == ADDR) ? w_addrPtr : r_ptr;
  assign w_fetchWord = r_mem[w_fetchPtr[PW-1:2]];

  always_comb begin
    w_fetchByte = w_fetchWord[31:24];
    case (w_fetchPtr[1:0])
      2'd1:    w_fetchByte = w_fetchWord[23:16];
      2'd2:    w_fetchByte = w_fetchWord[15:8];
      2'd3:    w_fetchByte = w_fetchWord[7:0];
      default: w_fetchByte = w_fetchWord[31:24];
    endcase
  end

  always_ff @(posedge clock) begin
    if (load_en) r_mem[load_addr] <= load_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Deselect beats any simultaneous sck edge, so rise handling is only reached with ss low.
  always_comb begin
    w_nextState = r_state;
    if (r_state == IDLE) begin
      if (w_ssFall) w_nextState = CMD;
    end else if (spi_ss_n) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        CMD:  if (w_rise && r_bitCnt == 5'd7) w_nextState = w_opOk ? ADDR : IGNORE;
`ifdef SPI_FLASH_FAST_READ_EN
        ADDR:  if (w_rise && r_bitCnt == 5'd23) w_nextState = DUMMY;
        DUMMY: if (w_rise && r_bitCnt == 5'd7)  w_nextState = DATA;
`else
        ADDR:  if (w_rise && r_bitCnt == 5'd23) w_nextState = DATA;
`endif
        default: w_nextState = r_state;
      endcase
    end
  end

  always_comb begin
    busy        = (r_state != IDLE);
    cmd_err     = r_cmdErr;
    spi_miso    = r_miso;
    w_cmdErrSet = (r_state == CMD) && (w_nextState == IGNORE);
    w_enterData = (w_nextState == DATA) && (r_state != DATA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sckQ   <= 1'b0;
      r_ssQ    <= 1'b0;
      r_cmdErr <= 1'b0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_txByte <= '0;
      r_miso   <= 1'b0;
    end else begin
      r_sckQ   <= spi_sck;
      r_ssQ    <= spi_ss_n;
      r_cmdErr <= w_cmdErrSet;
      if (spi_ss_n || r_state == IDLE) begin
        r_bitCnt <= '0;
        r_shift  <= '0;
        r_miso   <= 1'b0;
      end else begin
        case (r_state)
          DATA: begin
            if (w_fall) begin
              r_miso <= r_txByte[7];
              if (r_bitCnt == 5'd7) begin
                r_bitCnt <= '0;
                r_ptr    <= w_ptrInc;
                r_txByte <= w_fetchByte;
              end else begin
                r_bitCnt <= r_bitCnt + 5'd1;
                r_txByte <= {r_txByte[6:0], 1'b0};
              end
            end
          end
          IGNORE: r_miso <= 1'b0;
          default: begin
            r_miso <= 1'b0;
            if (w_rise) begin
              r_shift  <= {r_shift[SHW-2:0], spi_mosi};
              r_bitCnt <= (w_nextState != r_state) ? 5'd0 : r_bitCnt + 5'd1;
              if (r_state == ADDR && w_nextState != ADDR) r_ptr <= w_addrPtr;
              if (w_enterData) r_txByte <= w_fetchByte;
            end
          end
        endcase
      end
    end
  end

endmodule
